// File: rtl/painter_pkg.sv
// painter_pkg: shared definitions for the frame painter.
//   - Colour codes for the 3-bit VGA adapter (BLACK, GREEN, YELLOW).
//   - Default drawable area of the adapter.
//   - Controller state encoding.
package painter_pkg;

   localparam logic [2:0] BLACK  = 3'b000;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b110;

   localparam int unsigned DefScreenW = 160;
   localparam int unsigned DefScreenH = 120;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StErasePipes,
      StEraseBird,
      StDrawPipes,
      StDrawBird,
      StFinish
   } state_t;

endpackage

// File: rtl/frame_painter_if.sv
// frame_painter_if: request/position bus from game logic plus the pixel-write
// bus towards the VGA adapter.
//   draw_frame, bird_y, pipe_x, pipe_gap_y : game logic -> painter
//   plot, x, y, colour                     : painter -> VGA adapter
//   busy, done                             : painter status
// modport master = game-logic / adapter side, modport slave = painter.
interface frame_painter_if #(
   parameter int unsigned NUM_PIPES = 2
);
   logic                   draw_frame;
   logic [6:0]             bird_y;
   logic [8*NUM_PIPES-1:0] pipe_x;
   logic [7*NUM_PIPES-1:0] pipe_gap_y;
   logic                   plot;
   logic [7:0]             x;
   logic [6:0]             y;
   logic [2:0]             colour;
   logic                   busy;
   logic                   done;

   modport master (
      output draw_frame, bird_y, pipe_x, pipe_gap_y,
      input  plot, x, y, colour, busy, done
   );

   modport slave (
      input  draw_frame, bird_y, pipe_x, pipe_gap_y,
      output plot, x, y, colour, busy, done
   );
endinterface

// File: rtl/rect_scanner.sv
// rect_scanner: walks a width x height rectangle anchored at (org_x, org_y),
// one position per step, in row-major or column-major order.
//   clk_i, rst_ni          : clock, async active-low reset
//   step_i                 : advance to the next position
//   col_major_i            : 1 = rows inner (column-major), 0 = columns inner
//   org_x_i, org_y_i       : rectangle origin (9-bit, may exceed the screen)
//   width_i, height_i      : rectangle size (>= 1)
//   x_o, y_o               : current position, truncated to screen widths
//   last_o                 : current position is the final one of the rectangle
//   clipped_o              : current position lies outside the screen
// The offsets wrap to zero after the last position, so the next rectangle
// starts immediately with no idle cycle.
module rect_scanner
   import painter_pkg::*;
#(
   parameter int unsigned SCREEN_W = DefScreenW,
   parameter int unsigned SCREEN_H = DefScreenH
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       step_i,
   input  logic       col_major_i,
   input  logic [8:0] org_x_i,
   input  logic [8:0] org_y_i,
   input  logic [8:0] width_i,
   input  logic [8:0] height_i,
   output logic [7:0] x_o,
   output logic [6:0] y_o,
   output logic       last_o,
   output logic       clipped_o
);

   logic [8:0] off_x_q, off_x_d;
   logic [8:0] off_y_q, off_y_d;
   logic [8:0] cur_x, cur_y;
   logic       x_end, y_end;

   assign cur_x     = org_x_i + off_x_q;
   assign cur_y     = org_y_i + off_y_q;
   assign x_end     = (off_x_q == width_i - 9'd1);
   assign y_end     = (off_y_q == height_i - 9'd1);
   assign last_o    = x_end && y_end;
   assign clipped_o = (cur_x >= 9'(SCREEN_W)) || (cur_y >= 9'(SCREEN_H));
   assign x_o       = cur_x[7:0];
   assign y_o       = cur_y[6:0];

   always_comb begin
      off_x_d = off_x_q;
      off_y_d = off_y_q;
      if (step_i) begin
         if (last_o) begin
            off_x_d = '0;
            off_y_d = '0;
         end else if (col_major_i) begin
            if (y_end) begin
               off_y_d = '0;
               off_x_d = off_x_q + 9'd1;
            end else begin
               off_y_d = off_y_q + 9'd1;
            end
         end else begin
            if (x_end) begin
               off_x_d = '0;
               off_y_d = off_y_q + 9'd1;
            end else begin
               off_x_d = off_x_q + 9'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         off_x_q <= '0;
         off_y_q <= '0;
      end else begin
         off_x_q <= off_x_d;
         off_y_q <= off_y_d;
      end
   end

endmodule

// File: rtl/frame_painter.sv
// frame_painter: on a draw_frame request snapshots bird/pipe positions, erases
// the previous frame's objects (or clears the whole screen on the first frame),
// then rasterises NUM_PIPES pipes with gaps and the bird, one pixel per clock.
//   CLOCK_50 : system clock
//   resetn   : async active-low reset
//   bus      : frame_painter_if.slave (request, positions, pixel bus, busy/done)
// Pixels whose 9-bit coordinates fall off-screen still take their cycle but
// are written with plot=0.
module frame_painter
   import painter_pkg::*;
#(
   parameter int unsigned NUM_PIPES = 2,
   parameter int unsigned PIPE_W    = 4,
   parameter int unsigned GAP_H     = 30,
   parameter int unsigned BIRD_SIZE = 3,
   parameter int unsigned BIRD_X    = 4,
   parameter int unsigned SCREEN_W  = DefScreenW,
   parameter int unsigned SCREEN_H  = DefScreenH
) (
   input  logic           CLOCK_50,
   input  logic           resetn,
   frame_painter_if.slave bus
);

   localparam logic [1:0] IdxLast = 2'(NUM_PIPES - 1);

   state_t     state_q;
   logic       plot_q, busy_q, done_q, first_frame_q;
   logic [7:0] x_q;
   logic [6:0] y_q;
   logic [2:0] colour_q;
   logic [1:0] pipe_idx_q;

   // Snapshots sized for the maximum pipe count; unused entries stay zero.
   logic [7:0] cur_px_q  [4];
   logic [6:0] cur_gy_q  [4];
   logic [7:0] prev_px_q [4];
   logic [6:0] cur_by_q, prev_by_q;

   logic [8:0] org_x, org_y, rect_w, rect_h;
   logic       col_major;
   logic [2:0] pix_colour;
   logic       scan_step, scan_last, scan_clipped;
   logic [7:0] scan_x;
   logic [6:0] scan_y;
   logic [8:0] gap_lo, gap_hi;
   logic       in_gap;

   assign scan_step = (state_q != StIdle) && (state_q != StFinish);

   assign gap_lo = {2'b00, cur_gy_q[pipe_idx_q]};
   assign gap_hi = gap_lo + 9'(GAP_H);
   // Clipped rows may alias after truncation, but they are never plotted.
   assign in_gap = ({2'b00, scan_y} >= gap_lo) && ({2'b00, scan_y} < gap_hi);

   // Rectangle and colour for the current phase.
   always_comb begin
      org_x      = '0;
      org_y      = '0;
      rect_w     = 9'(SCREEN_W);
      rect_h     = 9'(SCREEN_H);
      col_major  = 1'b0;
      pix_colour = BLACK;
      case (state_q)
         StErasePipes: begin
            org_x     = {1'b0, prev_px_q[pipe_idx_q]};
            rect_w    = 9'(PIPE_W);
            col_major = 1'b1;
         end
         StEraseBird: begin
            org_x  = 9'(BIRD_X);
            org_y  = {2'b00, prev_by_q};
            rect_w = 9'(BIRD_SIZE);
            rect_h = 9'(BIRD_SIZE);
         end
         StDrawPipes: begin
            org_x      = {1'b0, cur_px_q[pipe_idx_q]};
            rect_w     = 9'(PIPE_W);
            col_major  = 1'b1;
            pix_colour = in_gap ? BLACK : GREEN;
         end
         StDrawBird: begin
            org_x      = 9'(BIRD_X);
            org_y      = {2'b00, cur_by_q};
            rect_w     = 9'(BIRD_SIZE);
            rect_h     = 9'(BIRD_SIZE);
            pix_colour = YELLOW;
         end
         default: ;
      endcase
   end

   rect_scanner #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_scanner (
      .clk_i       (CLOCK_50),
      .rst_ni      (resetn),
      .step_i      (scan_step),
      .col_major_i (col_major),
      .org_x_i     (org_x),
      .org_y_i     (org_y),
      .width_i     (rect_w),
      .height_i    (rect_h),
      .x_o         (scan_x),
      .y_o         (scan_y),
      .last_o      (scan_last),
      .clipped_o   (scan_clipped)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         plot_q        <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         colour_q      <= BLACK;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         first_frame_q <= 1'b1;
         pipe_idx_q    <= '0;
         cur_by_q      <= '0;
         prev_by_q     <= '0;
         for (int i = 0; i < 4; i++) begin
            cur_px_q[i]  <= '0;
            cur_gy_q[i]  <= '0;
            prev_px_q[i] <= '0;
         end
      end else begin
         plot_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               busy_q <= 1'b0;
               // A request in the done cycle is deliberately dropped.
               if (bus.draw_frame && !done_q) begin
                  cur_by_q <= bus.bird_y;
                  for (int i = 0; i < int'(NUM_PIPES); i++) begin
                     cur_px_q[i] <= bus.pipe_x[8*i +: 8];
                     cur_gy_q[i] <= bus.pipe_gap_y[7*i +: 7];
                  end
                  pipe_idx_q <= '0;
                  state_q    <= first_frame_q ? StClear : StErasePipes;
               end
            end
            StFinish: begin
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               prev_by_q <= cur_by_q;
               for (int i = 0; i < 4; i++) begin
                  prev_px_q[i] <= cur_px_q[i];
               end
               state_q <= StIdle;
            end
            default: begin
               plot_q   <= !scan_clipped;
               x_q      <= scan_x;
               y_q      <= scan_y;
               colour_q <= pix_colour;
               busy_q   <= 1'b1;
               if (scan_last) begin
                  case (state_q)
                     StClear: begin
                        first_frame_q <= 1'b0;
                        state_q       <= StDrawPipes;
                     end
                     StErasePipes, StDrawPipes: begin
                        if (pipe_idx_q == IdxLast) begin
                           pipe_idx_q <= '0;
                           state_q    <= (state_q == StErasePipes) ? StEraseBird : StDrawBird;
                        end else begin
                           pipe_idx_q <= pipe_idx_q + 2'd1;
                        end
                     end
                     StEraseBird: state_q <= StDrawPipes;
                     StDrawBird:  state_q <= StFinish;
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.plot   = plot_q;
   assign bus.x      = x_q;
   assign bus.y      = y_q;
   assign bus.colour = colour_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_frame_painter.sv
// tb_frame_painter: directed frames for frame_painter with a pixel scoreboard.
// Expected pixel streams are built from a simple geometric model of each frame.
module tb_frame_painter;

   localparam int NP = 2;

   logic CLOCK_50 = 1'b0;
   logic resetn   = 1'b0;

   frame_painter_if #(.NUM_PIPES(NP)) bus ();

   frame_painter #(.NUM_PIPES(NP)) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t sb[$];
   int   errors = 0;
   int   checks = 0;

   int m_first = 1;
   int m_prev_px[NP];
   int m_prev_by = 0;
   int c_px[NP];
   int c_gy[NP];
   int c_by = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // kind: 0 = black, 1 = pipe (green outside gap), 2 = bird yellow
   task automatic push_pix(input int px, input int py, input int kind, input int gap);
      pix_t p;
      if (px < 160 && py < 120) begin
         p.x = 8'(px);
         p.y = 7'(py);
         if (kind == 0) p.c = 3'b000;
         else if (kind == 2) p.c = 3'b110;
         else p.c = (py >= gap && py < gap + 30) ? 3'b000 : 3'b010;
         sb.push_back(p);
      end
   endtask

   task automatic push_rect(input int ox, input int oy, input int w, input int h,
                            input bit colm, input int kind, input int gap);
      if (colm) begin
         for (int c = 0; c < w; c++)
            for (int r = 0; r < h; r++) push_pix(ox + c, oy + r, kind, gap);
      end else begin
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) push_pix(ox + c, oy + r, kind, gap);
      end
   endtask

   task automatic push_frame();
      if (m_first != 0) begin
         push_rect(0, 0, 160, 120, 1'b0, 0, 0);
      end else begin
         for (int i = 0; i < NP; i++) push_rect(m_prev_px[i], 0, 4, 120, 1'b1, 0, 0);
         push_rect(4, m_prev_by, 3, 3, 1'b0, 0, 0);
      end
      for (int i = 0; i < NP; i++) push_rect(c_px[i], 0, 4, 120, 1'b1, 1, c_gy[i]);
      push_rect(4, c_by, 3, 3, 1'b0, 2, 0);
   endtask

   task automatic commit();
      m_first = 0;
      m_prev_by = c_by;
      for (int i = 0; i < NP; i++) m_prev_px[i] = c_px[i];
   endtask

   task automatic set_inputs(input int bird, input int p0, input int p1,
                             input int g0, input int g1);
      c_by = bird;
      c_px[0] = p0;
      c_px[1] = p1;
      c_gy[0] = g0;
      c_gy[1] = g1;
      bus.bird_y     = 7'(bird);
      bus.pipe_x     = {8'(p1), 8'(p0)};
      bus.pipe_gap_y = {7'(g1), 7'(g0)};
   endtask

   task automatic start(input bit hold);
      @(posedge CLOCK_50);
      #1 bus.draw_frame = 1'b1;
      @(posedge CLOCK_50);
      #1 if (!hold) bus.draw_frame = 1'b0;
   endtask

   // Consumes pixels until done (or stop_after plots when non-zero).
   task automatic watch_frame(input string tag, input int exp_busy, input int stop_after);
      int   busy_n = 0;
      int   plots = 0;
      int   cyc = 0;
      bit   seen_done = 1'b0;
      pix_t p;
      while (cyc < 30000) begin
         @(negedge CLOCK_50);
         cyc++;
         if (bus.busy) busy_n++;
         if (bus.plot) begin
            plots++;
            if (sb.size() == 0) begin
               check({tag, "_extra_pixel"}, sb.size(), 1);
            end else begin
               p = sb.pop_front();
               check({tag, "_pix"}, int'({bus.x, bus.y, bus.colour}), int'(p));
            end
            if (stop_after != 0 && plots == stop_after) return;
         end
         if (bus.done) begin
            seen_done = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, int'(seen_done), 1);
      check({tag, "_plot_at_done"}, int'(bus.plot), 0);
      check({tag, "_busy_at_done"}, int'(bus.busy), 0);
      check({tag, "_busy_cycles"}, busy_n, exp_busy);
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_plot"}, int'(bus.plot), 0);
      check({tag, "_x"}, int'(bus.x), 0);
      check({tag, "_y"}, int'(bus.y), 0);
      check({tag, "_colour"}, int'(bus.colour), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
   endtask

   initial begin
      bus.draw_frame = 1'b0;
      for (int i = 0; i < NP; i++) m_prev_px[i] = 0;
      set_inputs(0, 0, 0, 0, 0);
      #23;
      check_zero_outputs("reset");
      @(negedge CLOCK_50);
      resetn = 1'b1;

      // First frame: full clear, pipes, bird.
      set_inputs(50, 80, 120, 40, 10);
      push_frame();
      start(1'b0);
      watch_frame("frame1", 20169, 0);
      commit();
      @(negedge CLOCK_50);
      check("done_pulse_width", int'(bus.done), 0);

      // Second frame: erase old objects, draw shifted ones.
      set_inputs(51, 79, 119, 40, 10);
      push_frame();
      start(1'b0);
      watch_frame("frame2", 1938, 0);
      commit();

      // Clipping: pipe off right edge, gap and bird past the bottom.
      set_inputs(118, 158, 20, 100, 5);
      push_frame();
      start(1'b0);
      watch_frame("clip", 1938, 0);
      commit();

      // draw_frame held high: one frame per idle visit, none while busy.
      push_frame();
      start(1'b1);
      watch_frame("hold1", 1938, 0);
      commit();
      push_frame();
      @(posedge CLOCK_50);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("done_cycle_ignored_busy", int'(bus.busy), 0);
      check("done_cycle_ignored_plot", int'(bus.plot), 0);
      watch_frame("hold2", 1938, 0);
      bus.draw_frame = 1'b0;
      commit();

      // Reset in the middle of a frame, then a fresh frame must clear.
      set_inputs(60, 30, 90, 20, 50);
      push_frame();
      start(1'b0);
      watch_frame("mid", 0, 500);
      #2 resetn = 1'b0;
      #1 check_zero_outputs("mid_reset");
      sb.delete();
      m_first = 1;
      m_prev_by = 0;
      for (int i = 0; i < NP; i++) m_prev_px[i] = 0;
      @(negedge CLOCK_50);
      resetn = 1'b1;
      push_frame();
      start(1'b0);
      watch_frame("after_reset", 20169, 0);
      commit();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_painter.md
# frame_painter

Parametrised successor to the single-pipe painter: on each `draw_frame` request it snapshots the bird and all pipe positions, erases the previous frame's objects, then rasterises N pipes (with gaps) and the bird into the VGA adapter's pixel-write port, one pixel per clock. It sits between the game-logic block, which produces object positions, and the 160x120, 3-bit-colour VGA adapter. It replaces combinational "state" outputs with registered pixel outputs and a busy/done handshake.

## Interface
- `NUM_PIPES`, 2: number of pipes drawn per frame (1..4)
- `PIPE_W`, 4: pipe width in columns
- `GAP_H`, 30: gap height in rows
- `BIRD_SIZE`, 3: bird square side in pixels
- `BIRD_X`, 4: fixed bird left column
- `SCREEN_W`, 160; `SCREEN_H`, 120: drawable area
- `CLOCK_50`  in  1  system clock; all state on its rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `draw_frame`  in  1  frame request pulse; sampled only in IDLE
- `bird_y`  in  7  bird top row
- `pipe_x`  in  8*NUM_PIPES  packed pipe left columns, pipe i at [8i+7:8i]
- `pipe_gap_y`  in  7*NUM_PIPES  packed gap top rows, pipe i at [7i+6:7i]
- `plot`  out  1  pixel write enable to VGA adapter
- `x`  out  8  pixel column
- `y`  out  7  pixel row
- `colour`  out  3  pixel colour
- `busy`  out  1  high from accept until frame complete
- `done`  out  1  one-cycle pulse when frame complete

## Operation
- States: IDLE, CLEAR, ERASE_PIPES, ERASE_BIRD, DRAW_PIPES, DRAW_BIRD, FINISH.
- IDLE: `draw_frame`=1 → latch `bird_y`, `pipe_x`, `pipe_gap_y` into current snapshot; go to CLEAR if `first_frame` flag set, else ERASE_PIPES.
- CLEAR: scan full screen row-major, colour black; clear `first_frame`; then DRAW_PIPES.
- ERASE_PIPES / ERASE_BIRD: redraw previous-snapshot pipes and bird geometry in black (gap rows included).
- DRAW_PIPES: pipe 0 first; per pipe, column-major: col 0..PIPE_W-1, row 0..SCREEN_H-1. Colour green (3'b010) outside gap, black inside rows `gap_y`..`gap_y`+GAP_H-1.
- DRAW_BIRD: row-major BIRD_SIZE×BIRD_SIZE from (BIRD_X, bird_y), colour yellow (3'b110).
- FINISH: copy current snapshot to previous snapshot; pulse `done`; return to IDLE.
- Clipping: pixel with x ≥ SCREEN_W or y ≥ SCREEN_H still consumes its cycle but drives `plot`=0; gap extending past bottom is clipped likewise. x/y arithmetic is 9-bit internally to detect overflow; outputs are truncated.
- `draw_frame` outside IDLE is ignored (not queued).

## Timing
- Reset (async): state IDLE, `plot`=0, `x`=0, `y`=0, `colour`=0, `busy`=0, `done`=0, `first_frame`=1, snapshots zero. Reset mid-frame abandons the frame; next frame performs CLEAR.
- All outputs registered. Accept at edge t → first pixel valid in cycle t+1; `busy`=1 from t+1.
- One pixel per cycle, no bubbles between phases.
- P = NUM_PIPES·PIPE_W·SCREEN_H, B = BIRD_SIZE². First frame: 19200+P+B pixel cycles; later frames: 2(P+B). Defaults: 20169 / 1938.
- Cycle after last pixel: `plot`=0, `done`=1, `busy`=0; `draw_frame` is accepted in the following cycle.
- `draw_frame` coincident with `done` is ignored.

## Structure
- Shared package `painter_pkg`: colour constants (BLACK, GREEN, YELLOW), state enum, default screen dimensions.
- One sub-module `rect_scanner`: given origin, width, height and order (row/column-major), steps x/y per `step`, flags `last` and `clipped`; reused by every phase.

## Test plan
- Reset, `draw_frame` pulse, bird_y=50, pipes x={80,120}, gap_y={40,10} → CLEAR writes 19200 black pixels, then 960 pipe pixels (rows 40..69 black for pipe 0), 9 yellow bird pixels at x 4..6, y 50..52; `done` after 20169 cycles.
- Second frame with pipes x={79,119}, bird_y=51 → 969 black erase pixels at old positions, then 969 draw pixels; `done` after 1938 cycles.
- Pipe x=158, PIPE_W=4 → columns 160,161 produce `plot`=0; cycle count unchanged.
- gap_y=100, GAP_H=30 → rows 100..119 black, no writes beyond row 119; bird_y=118 → rows 120 clipped.
- `draw_frame` held high throughout a frame → exactly one frame per IDLE visit; no accept while `busy`.
- `resetn` low at pixel 500 → outputs zero immediately; next frame begins with full CLEAR.
